// File: rtl/lfsr_checker.sv
// ============================================================================
//  Module   : lfsr_checker
//  Purpose  : Self-synchronising serial PRBS checker with lock detection,
//             lock-loss supervision and saturating error/bit statistics.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_checker #(
    parameter int             N        = 3,
    parameter logic [N-1:0]   TAPS     = 3'b011,
    parameter int             LOCK_CNT = 4,
    parameter int             WIN      = 16,
    parameter int             LOSS_THR = 4,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int                    c_FILL_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_FILL_W-1:0]   c_FILL_LAST = c_FILL_W'(N - 1);
    localparam logic [c_FILL_W-1:0]   c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [7:0]            c_MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0]           c_WIN_LAST   = 16'(WIN - 1);
    localparam logic [15:0]           c_LOSS_LAST  = 16'(LOSS_THR - 1);

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        window_q, window_d;
    logic [c_FILL_W-1:0] fill_q, fill_d;
    logic [7:0]          match_q, match_d;
    logic [15:0]         blk_q, blk_d;
    logic [15:0]         blk_err_q, blk_err_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [CNT_W-1:0]    bit_count_q, bit_count_d;

    logic                w_pred;
    logic                w_mismatch;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_pred     = ^(window_q & TAPS);
    assign w_mismatch = in_bit ^ w_pred;

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        fill_d      = fill_q;
        match_d     = match_q;
        blk_d       = blk_q;
        blk_err_d   = blk_err_q;
        err_pulse_d = 1'b0;
        // clear zeroes first so a same-cycle event lands on top of zero
        err_count_d = clear ? '0 : err_count_q;
        bit_count_d = clear ? '0 : bit_count_q;

        if (in_valid) begin
            case (state_q)
                ST_SEED: begin
                    window_d = {in_bit, window_q[N-1:1]};
                    if (fill_q == c_FILL_LAST) begin
                        state_d = ST_LOCKING;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + c_FILL_ONE;
                    end
                end
                ST_LOCKING: begin
                    window_d = {in_bit, window_q[N-1:1]};
                    if (!w_mismatch && (|window_q)) begin
                        if (match_q == c_MATCH_LAST) begin
                            state_d   = ST_LOCKED;
                            match_d   = '0;
                            blk_d     = '0;
                            blk_err_d = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // free-run on the prediction so a channel error is not fed back
                    window_d    = {w_pred, window_q[N-1:1]};
                    bit_count_d = f_sat_inc(bit_count_d);
                    if (w_mismatch) begin
                        err_count_d = f_sat_inc(err_count_d);
                        err_pulse_d = 1'b1;
                    end
                    if (w_mismatch && (blk_err_q == c_LOSS_LAST)) begin
                        state_d   = ST_SEED;
                        fill_d    = '0;
                        match_d   = '0;
                        blk_d     = '0;
                        blk_err_d = '0;
                    end else if (blk_q == c_WIN_LAST) begin
                        blk_d     = '0;
                        blk_err_d = '0;
                    end else begin
                        blk_d = blk_q + 16'd1;
                        if (w_mismatch) begin
                            blk_err_d = blk_err_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SEED;
            window_q    <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            blk_q       <= '0;
            blk_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            blk_q       <= blk_d;
            blk_err_q   <= blk_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

`default_nettype wire
